muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The module SHALL have parameter DATA_SIZE, default 32, giving the operand, HI and LO width.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request a new operation; sampled only while busy=0.
REQ-005 op  input  2  operation: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
REQ-006 a  input  DATA_SIZE  multiplicand / dividend (rs value from the register file).
REQ-007 b  input  DATA_SIZE  multiplier / divisor (rt value from the register file).
REQ-008 wr_hi, wr_lo  input  1 each  direct writes of HI / LO (mthi / mtlo).
REQ-009 wdata  input  DATA_SIZE  data for wr_hi / wr_lo.
REQ-010 hi, lo  output  DATA_SIZE each  architectural HI / LO registers, feeding the writeback mux (mfhi / mflo).
REQ-011 busy  output  1  high while an operation is in progress.
REQ-012 done  output  1  one-cycle pulse on the cycle that the new HI/LO first become visible.
REQ-013 div_by_zero  output  1  sticky flag for the last completed operation; set on divide with b=0.

Function
REQ-014 The FSM SHALL have exactly the states IDLE, CALC and FINISH.
REQ-015 In IDLE with start=1 the unit SHALL latch a, b and op, load the counter with DATA_SIZE, and go to CALC; busy SHALL be 1 from the next cycle on.
REQ-016 In CALC the unit SHALL perform one iteration per cycle and decrement the counter; it SHALL go to FINISH after the iteration in which the counter reaches 0.
REQ-017 Multiply SHALL use radix-2 shift-add on operand magnitudes, with a 2*DATA_SIZE-bit accumulator.
REQ-018 Divide SHALL use radix-2 restoring division on operand magnitudes.
REQ-019 For signed operations the unit SHALL correct the result sign at the end.
REQ-020 In FINISH the unit SHALL write HI/LO, pulse done=1, drop busy, and return to IDLE; this gives a fixed latency of DATA_SIZE+2 edges from the start edge to the done cycle.
REQ-021 MULT/MULTU SHALL produce {hi,lo} = full 2*DATA_SIZE-bit product, interpreted as signed for MULT and unsigned for MULTU.
REQ-022 DIV SHALL set lo = quotient truncated toward zero and hi = remainder, which has the sign of the dividend.
REQ-023 DIVU SHALL produce the unsigned quotient in lo and the unsigned remainder in hi.
REQ-024 DIV with a = most negative value and b = -1 SHALL give lo = 0x80000000 and hi = 0, with no flag raised.
REQ-025 For DIV/DIVU with b = 0, the unit SHALL skip CALC, enter FINISH on the next edge, set hi = a, lo = all ones and div_by_zero = 1.
REQ-026 Any other completed operation SHALL clear div_by_zero.
REQ-027 start while busy=1 SHALL be ignored and SHALL NOT alter the operation in progress.
REQ-028 wr_hi / wr_lo SHALL update HI / LO on the next edge only when busy=0 and the unit is not in FINISH; they SHALL be ignored otherwise.
REQ-029 If start and wr_hi / wr_lo are asserted in the same IDLE cycle, the direct write SHALL take effect and the operation SHALL start; the operation result later overwrites HI/LO.
REQ-030 hi and lo SHALL hold their previous values throughout CALC; no partial results SHALL be visible.
REQ-031 done SHALL be a registered output asserted for exactly one cycle per accepted start.

Reset
REQ-032 While rst=1, regardless of clock, the FSM SHALL go to IDLE and hi=0, lo=0, busy=0, done=0, div_by_zero=0, counter=0.
REQ-033 Reset asserted mid-CALC SHALL abort the operation, SHALL NOT produce a done pulse, and SHALL leave HI/LO at 0.
REQ-034 After rst deasserts, the first start on a clock edge SHALL be accepted normally.

Verification
REQ-035 Run MULT with a=-3, b=7 -> after 34 edges done=1, hi=0xFFFFFFFF, lo=0xFFFFFFEB, div_by_zero=0.
REQ-036 Run MULTU with a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-037 Run DIV with a=-7, b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); then DIVU with a=7, b=2 -> lo=3, hi=1.
REQ-038 Run DIV with a=5, b=0 -> done on the 2nd edge after start, hi=5, lo=0xFFFFFFFF, div_by_zero=1; a following MULT SHALL clear div_by_zero.
REQ-039 Assert start mid-CALC and wr_hi during busy -> both ignored; the original result completes unchanged with exactly one done pulse.
REQ-040 Assert rst at CALC cycle 10 -> busy=0 and hi=lo=0 immediately, no done; a new MULT with a=2, b=3 after release -> lo=6, hi=0.

Source files
------------

// File: rtl/muldiv_if.sv
`default_nettype none
// =============================================================================
// muldiv_if : operation request, HI/LO direct-write and result bundle
// Rev 1.0
// =============================================================================
interface muldiv_if #(
   parameter int DATA_SIZE = 32
);
   logic                 start;
   logic [1:0]           op;
   logic [DATA_SIZE-1:0] a;
   logic [DATA_SIZE-1:0] b;
   logic                 wr_hi;
   logic                 wr_lo;
   logic [DATA_SIZE-1:0] wdata;
   logic [DATA_SIZE-1:0] hi;
   logic [DATA_SIZE-1:0] lo;
   logic                 busy;
   logic                 done;
   logic                 div_by_zero;

   modport master (
      output start, op, a, b, wr_hi, wr_lo, wdata,
      input  hi, lo, busy, done, div_by_zero
   );

   modport slave (
      input  start, op, a, b, wr_hi, wr_lo, wdata,
      output hi, lo, busy, done, div_by_zero
   );
endinterface
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// =============================================================================
// muldiv_unit : iterative radix-2 MULT/MULTU/DIV/DIVU unit owning HI/LO
// Rev 1.0
// =============================================================================
module muldiv_unit #(
   parameter int DATA_SIZE = 32
) (
   input  wire logic clk,
   input  wire logic rst,
   muldiv_if.slave   bus
);
   localparam int CNT_W = $clog2(DATA_SIZE + 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CALC   = 2'd1,
      FINISH = 2'd2
   } state_t;

   state_t                 state;
   state_t                 state_next;

   logic [1:0]             op_lat;
   logic [DATA_SIZE-1:0]   a_lat;
   logic [DATA_SIZE-1:0]   opnd;
   logic [2*DATA_SIZE-1:0] acc;
   logic [CNT_W-1:0]       count;
   logic                   neg_a;
   logic                   neg_b;
   logic                   zero_div;
   logic [DATA_SIZE-1:0]   hi_value;
   logic [DATA_SIZE-1:0]   lo_value;
   logic                   done_pulse;
   logic                   dz_flag;

   logic                   in_neg_a;
   logic                   in_neg_b;
   logic                   b_is_zero;
   logic [DATA_SIZE-1:0]   mag_a;
   logic [DATA_SIZE-1:0]   mag_b;

   logic [DATA_SIZE-1:0]   addend;
   logic [DATA_SIZE:0]     mul_sum;
   logic [2*DATA_SIZE-1:0] mul_step;
   logic [DATA_SIZE:0]     div_shift;
   logic [DATA_SIZE:0]     div_trial;
   logic                   div_fits;
   logic [DATA_SIZE-1:0]   div_rem;
   logic [2*DATA_SIZE-1:0] div_step;

   logic [2*DATA_SIZE-1:0] prod;
   logic [DATA_SIZE-1:0]   quot;
   logic [DATA_SIZE-1:0]   rem;
   logic [DATA_SIZE-1:0]   res_hi;
   logic [DATA_SIZE-1:0]   res_lo;

   // op[0]=0 selects the signed variants
   assign in_neg_a  = ~bus.op[0] & bus.a[DATA_SIZE-1];
   assign in_neg_b  = ~bus.op[0] & bus.b[DATA_SIZE-1];
   assign mag_a     = in_neg_a ? -bus.a : bus.a;
   assign mag_b     = in_neg_b ? -bus.b : bus.b;
   assign b_is_zero = (bus.b == '0);

   // Multiply: acc = {partial, multiplier}; add and shift right each cycle
   assign addend   = acc[0] ? opnd : '0;
   assign mul_sum  = {1'b0, acc[2*DATA_SIZE-1:DATA_SIZE]} + {1'b0, addend};
   assign mul_step = {mul_sum, acc[DATA_SIZE-1:1]};

   // Divide: acc = {remainder, dividend/quotient}; quotient bits shift in at LSB
   assign div_shift = {acc[2*DATA_SIZE-1:DATA_SIZE], acc[DATA_SIZE-1]};
   assign div_trial = div_shift - {1'b0, opnd};
   assign div_fits  = ~div_trial[DATA_SIZE];
   assign div_rem   = div_fits ? div_trial[DATA_SIZE-1:0] : div_shift[DATA_SIZE-1:0];
   assign div_step  = {div_rem, acc[DATA_SIZE-2:0], div_fits};

   assign prod = (neg_a ^ neg_b) ? -acc : acc;
   assign quot = (neg_a ^ neg_b) ? -acc[DATA_SIZE-1:0] : acc[DATA_SIZE-1:0];
   assign rem  = neg_a ? -acc[2*DATA_SIZE-1:DATA_SIZE] : acc[2*DATA_SIZE-1:DATA_SIZE];

   always_comb begin
      res_hi = prod[2*DATA_SIZE-1:DATA_SIZE];
      res_lo = prod[DATA_SIZE-1:0];
      if (zero_div) begin
         res_hi = a_lat;
         res_lo = '1;
      end else if (op_lat[1]) begin
         res_hi = rem;
         res_lo = quot;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (bus.start) begin
               state_next = (bus.op[1] && b_is_zero) ? FINISH : CALC;
            end
         end
         CALC: begin
            if (count == CNT_W'(1)) begin
               state_next = FINISH;
            end
         end
         FINISH:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_lat     <= '0;
         a_lat      <= '0;
         opnd       <= '0;
         acc        <= '0;
         count      <= '0;
         neg_a      <= 1'b0;
         neg_b      <= 1'b0;
         zero_div   <= 1'b0;
         hi_value   <= '0;
         lo_value   <= '0;
         done_pulse <= 1'b0;
         dz_flag    <= 1'b0;
      end else begin
         done_pulse <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.wr_hi) hi_value <= bus.wdata;
               if (bus.wr_lo) lo_value <= bus.wdata;
               if (bus.start) begin
                  op_lat   <= bus.op;
                  a_lat    <= bus.a;
                  neg_a    <= in_neg_a;
                  neg_b    <= in_neg_b;
                  count    <= CNT_W'(DATA_SIZE);
                  zero_div <= bus.op[1] && b_is_zero;
                  if (bus.op[1]) begin
                     acc  <= {{DATA_SIZE{1'b0}}, mag_a};
                     opnd <= mag_b;
                  end else begin
                     acc  <= {{DATA_SIZE{1'b0}}, mag_b};
                     opnd <= mag_a;
                  end
               end
            end
            CALC: begin
               count <= count - 1'b1;
               acc   <= op_lat[1] ? div_step : mul_step;
            end
            FINISH: begin
               hi_value   <= res_hi;
               lo_value   <= res_lo;
               done_pulse <= 1'b1;
               dz_flag    <= zero_div;
            end
            default: ;
         endcase
      end
   end

   assign bus.hi          = hi_value;
   assign bus.lo          = lo_value;
   assign bus.busy        = (state != IDLE);
   assign bus.done        = done_pulse;
   assign bus.div_by_zero = dz_flag;
endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// =============================================================================
// tb_muldiv_unit : directed vectors, expected results queued to a done monitor
// Rev 1.0
// =============================================================================
module tb_muldiv_unit;
   localparam int N = 32;
   localparam int LAT_FULL = N + 2;
   localparam int LAT_DZ   = 2;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   muldiv_if #(.DATA_SIZE(N)) bus ();
   muldiv_unit #(.DATA_SIZE(N)) dut (.clk(clk), .rst(rst), .bus(bus));

   typedef struct {
      logic [N-1:0] hi;
      logic [N-1:0] lo;
      logic         dz;
      int           issue;
      int           lat;
      int           id;
   } exp_t;

   exp_t sb[$];
   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int dones  = 0;
   int pushes = 0;

   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (bus.done === 1'b1) begin
         dones++;
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done=1 expected no pending operation");
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk($sformatf("op%0d_hi", e.id), 64'(bus.hi), 64'(e.hi));
            chk($sformatf("op%0d_lo", e.id), 64'(bus.lo), 64'(e.lo));
            chk($sformatf("op%0d_dz", e.id), 64'(bus.div_by_zero), 64'(e.dz));
            chk($sformatf("op%0d_latency", e.id), 64'(cyc - e.issue), 64'(e.lat));
         end
      end
   end

   // Called right after a falling edge; start is sampled on the next rising edge
   task automatic issue(input logic [1:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic [N-1:0] eh, input logic [N-1:0] el, input logic edz,
                        input int lat);
      exp_t e;
      bus.op    = op;
      bus.a     = a;
      bus.b     = b;
      bus.start = 1'b1;
      e.hi = eh; e.lo = el; e.dz = edz; e.issue = cyc; e.lat = lat; e.id = pushes;
      sb.push_back(e);
      pushes++;
      @(negedge clk);
      bus.start = 1'b0;
      chk("busy_after_start", 64'(bus.busy), 64'd1);
   endtask

   task automatic wait_done();
      int t = 0;
      while (dones < pushes && t < 100) begin
         @(negedge clk);
         t++;
      end
      checks++;
      if (dones < pushes) begin
         errors++;
         $display("FAIL done_timeout: got %0d dones expected %0d", dones, pushes);
      end
   endtask

   initial begin
      rst = 1'b1;
      bus.start = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0;
      bus.wr_hi = 1'b0; bus.wr_lo = 1'b0; bus.wdata = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("reset_hi",   64'(bus.hi), 64'd0);
      chk("reset_lo",   64'(bus.lo), 64'd0);
      chk("reset_busy", 64'(bus.busy), 64'd0);
      chk("reset_done", 64'(bus.done), 64'd0);
      chk("reset_dz",   64'(bus.div_by_zero), 64'd0);

      // mthi / mtlo while idle
      bus.wr_hi = 1'b1; bus.wdata = 32'h0000_1234;
      @(negedge clk);
      bus.wr_hi = 1'b0;
      chk("mthi", 64'(bus.hi), 64'h1234);
      bus.wr_lo = 1'b1; bus.wdata = 32'h0000_5678;
      @(negedge clk);
      bus.wr_lo = 1'b0;
      chk("mtlo", 64'(bus.lo), 64'h5678);

      issue(2'b00, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, LAT_FULL);
      wait_done();
      issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, LAT_FULL);
      wait_done();
      issue(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, LAT_FULL);
      wait_done();
      issue(2'b11, 32'd7, 32'd2, 32'd1, 32'd3, 1'b0, LAT_FULL);
      wait_done();
      issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, LAT_FULL);
      wait_done();
      issue(2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0, LAT_FULL);
      wait_done();
      issue(2'b11, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF, 1'b0, LAT_FULL);
      wait_done();
      issue(2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0, 1'b0, LAT_FULL);
      wait_done();

      // divide by zero, then a multiply clears the flag
      issue(2'b10, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1, LAT_DZ);
      wait_done();
      issue(2'b00, 32'd4, 32'd5, 32'd0, 32'd20, 1'b0, LAT_FULL);
      wait_done();

      // direct write and start in the same idle cycle
      bus.wr_lo = 1'b1; bus.wdata = 32'h0000_AAAA;
      issue(2'b00, 32'd2, 32'd2, 32'd0, 32'd4, 1'b0, LAT_FULL);
      bus.wr_lo = 1'b0;
      chk("same_cycle_mtlo", 64'(bus.lo), 64'hAAAA);
      wait_done();

      // start and HI/LO writes while busy are ignored
      issue(2'b01, 32'd100, 32'd200, 32'd0, 32'd20000, 1'b0, LAT_FULL);
      repeat (10) @(negedge clk);
      chk("calc_hi_hold", 64'(bus.hi), 64'd0);
      chk("calc_lo_hold", 64'(bus.lo), 64'd4);
      bus.start = 1'b1; bus.op = 2'b11; bus.a = 32'd1; bus.b = 32'd1;
      bus.wr_hi = 1'b1; bus.wr_lo = 1'b1; bus.wdata = 32'h0000_DEAD;
      @(negedge clk);
      bus.start = 1'b0; bus.wr_hi = 1'b0; bus.wr_lo = 1'b0;
      chk("busy_write_hi_ignored", 64'(bus.hi), 64'd0);
      chk("busy_write_lo_ignored", 64'(bus.lo), 64'd4);
      wait_done();
      repeat (40) @(negedge clk);
      chk("no_extra_done", 64'(dones), 64'(pushes));
      chk("idle_after_ignored_start", 64'(bus.busy), 64'd0);

      // reset mid-CALC: no result, no done
      bus.start = 1'b1; bus.op = 2'b00; bus.a = 32'd9; bus.b = 32'd9;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (9) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("rst_mid_busy", 64'(bus.busy), 64'd0);
      chk("rst_mid_hi",   64'(bus.hi), 64'd0);
      chk("rst_mid_lo",   64'(bus.lo), 64'd0);
      chk("rst_mid_done", 64'(bus.done), 64'd0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (40) @(negedge clk);
      chk("no_done_after_abort", 64'(dones), 64'(pushes));
      chk("hi_zero_after_abort", 64'(bus.hi), 64'd0);

      issue(2'b00, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0, LAT_FULL);
      wait_done();

      repeat (3) @(negedge clk);
      chk("scoreboard_empty", 64'(sb.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
